// File: rtl/riscv_rf_sb.sv
// Multi-port integer register file with per-register busy scoreboard and debug port; zero-latency reads, writes commit on the rising edge.
// No backpressure: every write and issue mark is accepted each cycle. Define RISCV_RF_SB_BYPASS_EN for same-cycle write-to-read bypass.
module riscv_rf_sb #(
    parameter int XLEN    = 32,
    parameter int AR_BITS = 5,
    parameter int RDPORTS = 2,
    parameter int WRPORTS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RDPORTS*AR_BITS-1:0] rf_src,
    output logic [RDPORTS*XLEN-1:0]    rf_srcv,
    output logic [RDPORTS-1:0]         rf_src_busy,
    input  logic [WRPORTS*AR_BITS-1:0] rf_dst,
    input  logic [WRPORTS*XLEN-1:0]    rf_dstv,
    input  logic [WRPORTS-1:0]         rf_we,
    input  logic [AR_BITS-1:0]         is_dst,
    input  logic                       is_set,
    input  logic                       sb_flush,
    input  logic                       du_we_rf,
    input  logic [AR_BITS-1:0]         du_addr,
    input  logic [XLEN-1:0]            du_dati,
    output logic [XLEN-1:0]            du_dato
);
    localparam int NREGS = 1 << AR_BITS;

    logic [XLEN-1:0]    regs [NREGS];
    logic [NREGS-1:0]   busy;
    logic [NREGS-1:0]   busy_nxt;
    logic [AR_BITS-1:0] dst_a  [WRPORTS];
    logic [XLEN-1:0]    dstv_a [WRPORTS];

    for (genvar w = 0; w < WRPORTS; w++) begin : g_wr
        assign dst_a[w]  = rf_dst[w*AR_BITS +: AR_BITS];
        assign dstv_a[w] = rf_dstv[w*XLEN +: XLEN];
    end

    // Later assignments take priority: set beats write-clear, flush beats everything.
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < WRPORTS; w++) begin
            if (rf_we[w]) busy_nxt[dst_a[w]] = 1'b0;
        end
        if (is_set) busy_nxt[is_dst] = 1'b1;
        if (sb_flush) busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    // Loop order gives the higher write port priority; the debug write overrides both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int w = 0; w < WRPORTS; w++) begin
                if (rf_we[w] && dst_a[w] != '0) regs[dst_a[w]] <= dstv_a[w];
            end
            if (du_we_rf && du_addr != '0) regs[du_addr] <= du_dati;
            busy <= busy_nxt;
        end
    end

    for (genvar p = 0; p < RDPORTS; p++) begin : g_rd
        logic [AR_BITS-1:0] src;
        logic [XLEN-1:0]    val;
        logic               bz;

        assign src = rf_src[p*AR_BITS +: AR_BITS];

        always_comb begin
            val = regs[src];
            bz  = busy[src];
`ifdef RISCV_RF_SB_BYPASS_EN
            for (int w = 0; w < WRPORTS; w++) begin
                if (rf_we[w] && dst_a[w] == src) begin
                    val = dstv_a[w];
                    bz  = 1'b0;
                end
            end
`endif
            if (src == '0) begin
                val = '0;
                bz  = 1'b0;
            end
        end

        assign rf_srcv[p*XLEN +: XLEN] = val;
        assign rf_src_busy[p]          = bz;
    end

    assign du_dato = (du_addr == '0) ? '0 : regs[du_addr];

endmodule
